// File: rtl/llrc_frame_ctrl.sv
// llrc_frame_ctrl: frame sequencer for the LLR calculation datapath.
//
// Loads one OFDM symbol of channel weights (Kf) into the Kf RAM, then walks
// the Kf read address alongside the demapper metric stream (Mi). Each Mi
// sample is tagged first-pass (0) or second-pass (1). A {vld, tag} delay line
// matches the multiplier pipeline, so the FIFO write/read enables and the
// combiner strobe line up with the products they refer to.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         frame start pulse, accepted only when idle
//   kf_vld        Kf sample strobe (channel estimator)
//   mi_vld        Mi sample strobe (demapper)
//   fifo_full     pairing FIFO full
//   fifo_empty    pairing FIFO empty
//   kf_we         Kf RAM write enable (same cycle as kf_vld)
//   kf_waddr      Kf RAM write address
//   kf_raddr      Kf RAM read address (valid in the mi_vld cycle)
//   fifo_wr_en    store a first-pass product
//   fifo_rd_en    fetch the stored partner of a second-pass product
//   comb_vld      second-pass product and its partner are at the combiner
//   busy          not idle
//   done          one-cycle pulse when the frame has fully drained
//   err           sticky {underflow, overflow, sequence}, cleared on start
module llrc_frame_ctrl #(
  parameter int unsigned NSC      = 480,
  parameter int unsigned NPASS    = 8640,
  parameter int unsigned PIPE_LAT = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned AW       = 9,
  parameter int unsigned CW       = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          kf_vld,
  input  logic          mi_vld,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic          kf_we,
  output logic [AW-1:0] kf_waddr,
  output logic [AW-1:0] kf_raddr,
  output logic          fifo_wr_en,
  output logic          fifo_rd_en,
  output logic          comb_vld,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err
);

  typedef enum logic [1:0] {StIdle, StLoadKf, StStream, StDrain} state_e;

  localparam logic [AW-1:0] KfLast   = AW'(NSC - 1);
  localparam logic [CW-1:0] PassLast = CW'(NPASS - 1);
  // Delay-line bit k-1 holds a sample k cycles after its mi_vld.
  localparam int unsigned LastIdx = PIPE_LAT - 1;
  localparam int unsigned RdIdx   = PIPE_LAT - RD_LAT - 1;

  state_e              state_q, state_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [CW-1:0]       mi_cnt_q, mi_cnt_d;
  logic                tag_q, tag_d;
  logic [PIPE_LAT-1:0] dl_vld_q, dl_vld_d;
  logic [PIPE_LAT-1:0] dl_tag_q, dl_tag_d;
  logic [2:0]          err_q, err_d;

  logic start_ok, kf_ok, mi_ok, seq_err;
  logic wr_req, rd_req, dl_empty;

  // Strobe qualification and delay-line taps.
  always_comb begin
    start_ok = start  && (state_q == StIdle);
    kf_ok    = kf_vld && (state_q == StLoadKf);
    mi_ok    = mi_vld && (state_q == StStream);
    seq_err  = (start && !start_ok) || (kf_vld && !kf_ok) || (mi_vld && !mi_ok);
    wr_req   = dl_vld_q[LastIdx] && !dl_tag_q[LastIdx];
    rd_req   = dl_vld_q[RdIdx] && dl_tag_q[RdIdx];
    dl_empty = (dl_vld_q == '0);
  end

  // Outputs.
  always_comb begin
    kf_we      = kf_ok;
    kf_waddr   = waddr_q;
    kf_raddr   = raddr_q;
    // A write into a full FIFO is dropped; the overflow flag records it.
    fifo_wr_en = wr_req && !fifo_full;
    // Reads are issued even when empty; the underflow flag marks the result bad.
    fifo_rd_en = rd_req;
    comb_vld   = dl_vld_q[LastIdx] && dl_tag_q[LastIdx];
    busy       = (state_q != StIdle);
    done       = (state_q == StDrain) && dl_empty;
    err        = err_q;
  end

  // Next state.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    mi_cnt_d = mi_cnt_q;
    tag_d    = tag_q;
    dl_vld_d = {dl_vld_q[PIPE_LAT-2:0], mi_ok};
    dl_tag_d = {dl_tag_q[PIPE_LAT-2:0], tag_q};
    err_d    = (start_ok ? 3'b000 : err_q) |
               {rd_req && fifo_empty, wr_req && fifo_full, seq_err};

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d  = StLoadKf;
          waddr_d  = '0;
          raddr_d  = '0;
          mi_cnt_d = '0;
          tag_d    = 1'b0;
        end
      end
      StLoadKf: begin
        if (kf_ok) begin
          if (waddr_q == KfLast) begin
            waddr_d = '0;
            state_d = StStream;
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
      end
      StStream: begin
        if (mi_ok) begin
          if (mi_cnt_q == PassLast) begin
            // Pass boundary: second pass restarts the Kf walk from 0.
            mi_cnt_d = '0;
            tag_d    = !tag_q;
            raddr_d  = '0;
            if (tag_q) begin
              state_d = StDrain;
            end
          end else begin
            mi_cnt_d = mi_cnt_q + CW'(1);
            raddr_d  = (raddr_q == KfLast) ? '0 : raddr_q + AW'(1);
          end
        end
      end
      StDrain: begin
        if (dl_empty) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      waddr_q  <= '0;
      raddr_q  <= '0;
      mi_cnt_q <= '0;
      tag_q    <= 1'b0;
      dl_vld_q <= '0;
      dl_tag_q <= '0;
      err_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      mi_cnt_q <= mi_cnt_d;
      tag_q    <= tag_d;
      dl_vld_q <= dl_vld_d;
      dl_tag_q <= dl_tag_d;
      err_q    <= err_d;
    end
  end

endmodule
